// File: rtl/fetch_queue.sv
// fetch_queue: LC-3b instruction-fetch front end with a DEPTH-entry {instr, pc} queue feeding IF/ID.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           INSTR_WIDTH = 16,
  parameter int unsigned           DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           PC_STEP     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_WIDTH-1:0]      imem_address,
  output logic                       imem_read,
  input  logic [INSTR_WIDTH-1:0]     imem_rdata,
  input  logic                       imem_resp,
  output logic [1:0]                 imem_byte_enable,
  input  logic                       redirect_valid,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [INSTR_WIDTH-1:0]     deq_instr,
  output logic [ADDR_WIDTH-1:0]      deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW1-1:0]        DEPTH_C1 = CW1'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C   = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
  logic [ADDR_WIDTH-1:0]  pend_pc_q, pend_pc_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

  logic                   resp_ok, pop, enq, bypass, not_empty;
  logic [CW1-1:0]         cnt_after;
  logic [ADDR_WIDTH-1:0]  next_pc;

  assign not_empty = (count_q != '0);
  assign resp_ok   = imem_resp && !redirect_valid;
  assign pop       = not_empty && deq_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass    = (state_q == REQ) && resp_ok && !not_empty && deq_ready;
`else
  assign bypass    = 1'b0;
`endif
  assign enq       = (state_q == REQ) && resp_ok && !bypass;
  assign cnt_after = CW1'(count_q) + CW1'(enq) - CW1'(pop);
  assign next_pc   = req_pc_q + STEP_C;

  // Next-state: a new request is only issued while a queue slot is reserved for its response.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pend_pc_d  = pend_pc_q;
    count_d    = redirect_valid ? '0 : cnt_after[CW-1:0];
    wr_ptr_d   = redirect_valid ? '0 : wr_ptr_q + PW'(enq);
    rd_ptr_d   = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (count_q < DEPTH_C) begin
          req_pc_d = fetch_pc_q;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (imem_resp && redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = IDLE;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
          state_d   = DRAIN;
        end else if (imem_resp) begin
          fetch_pc_d = next_pc;
          if (cnt_after < DEPTH_C1) begin
            req_pc_d = next_pc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        // The old request stays on the bus; its data is dropped when it returns.
        if (imem_resp) begin
          fetch_pc_d = redirect_valid ? redirect_pc : pend_pc_q;
          state_d    = IDLE;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pend_pc_q  <= pend_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  // Head outputs read zero when nothing is available.
  always_comb begin
    deq_valid = not_empty;
    deq_instr = '0;
    deq_pc    = '0;
    if (not_empty) begin
      deq_instr = instr_mem[rd_ptr_q];
      deq_pc    = pc_mem[rd_ptr_q];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      deq_valid = 1'b1;
      deq_instr = imem_rdata;
      deq_pc    = req_pc_q;
    end
`endif
  end

  assign imem_read        = (state_q == REQ) || (state_q == DRAIN);
  assign imem_address     = req_pc_q;
  assign imem_byte_enable = 2'b11;
  assign count            = count_q;

  assert property (@(posedge clk) disable iff (reset) !(enq && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue with a latency-programmable memory responder
// and a transaction-level queue model of expected fetch addresses and decoded entries.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_address;
  logic          imem_read;
  logic [IW-1:0] imem_rdata;
  logic          imem_resp;
  logic [1:0]    imem_byte_enable;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          deq_ready;
  logic          deq_valid;
  logic [IW-1:0] deq_instr;
  logic [AW-1:0] deq_pc;
  logic [CW-1:0] count;

  fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk(clk), .reset(reset), .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .imem_byte_enable(imem_byte_enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  entry_t        mq[$];
  logic [AW-1:0] req_log[$];
  logic [AW-1:0] m_next, m_pend, open_addr;
  bit            m_discard, rd_prev, resp_prev, req_new;
  int            age, cur_lat, lat_mode, max_count, n_pops;

  task automatic model_reset();
    mq.delete();
    req_log.delete();
    m_next    = 16'h0000;
    m_pend    = 16'h0000;
    open_addr = 16'h0000;
    m_discard = 1'b0;
    rd_prev   = 1'b0;
    resp_prev = 1'b0;
    req_new   = 1'b0;
    age       = 0;
    max_count = 0;
  endtask

  task automatic do_reset();
    imem_resp      = 1'b0;
    redirect_valid = 1'b0;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One clock: compare against the model at the negedge, advance the model, then drive the responder.
  task automatic tick();
    bit     acc, byp;
    entry_t e;
    @(negedge clk);
    if (imem_read) begin
      if (req_new) begin
        n_checks++;
        if (imem_address !== m_next) begin
          n_errors++; $display("FAIL fetch_addr: got %h expected %h", imem_address, m_next);
        end
        n_checks++;
        if (mq.size() >= int'(DEPTH)) begin
          n_errors++; $display("FAIL req_space: request issued with %0d entries held, limit %0d", mq.size(), DEPTH);
        end
        open_addr = imem_address;
        req_log.push_back(imem_address);
      end else begin
        n_checks++;
        if (imem_address !== open_addr) begin
          n_errors++; $display("FAIL addr_stable: got %h expected %h", imem_address, open_addr);
        end
      end
    end
    acc = imem_read && imem_resp && !redirect_valid && !m_discard;
    byp = BYP && acc && (mq.size() == 0) && deq_ready;
    n_checks++;
    if (count !== CW'(mq.size())) begin
      n_errors++; $display("FAIL count: got %0d expected %0d", count, mq.size());
    end
    n_checks++;
    if (deq_valid !== ((mq.size() != 0) || byp)) begin
      n_errors++; $display("FAIL deq_valid: got %b expected %b", deq_valid, (mq.size() != 0) || byp);
    end
    if (mq.size() != 0) begin
      n_checks++;
      if (deq_pc !== mq[0].pc || deq_instr !== mq[0].instr) begin
        n_errors++; $display("FAIL deq_head: got pc %h instr %h expected pc %h instr %h",
                             deq_pc, deq_instr, mq[0].pc, mq[0].instr);
      end
    end else if (byp) begin
      n_checks++;
      if (deq_pc !== open_addr || deq_instr !== imem_rdata) begin
        n_errors++; $display("FAIL deq_bypass: got pc %h instr %h expected pc %h instr %h",
                             deq_pc, deq_instr, open_addr, imem_rdata);
      end
    end
    if (int'(count) > max_count) max_count = int'(count);
    if (mq.size() != 0 && deq_ready) begin
      void'(mq.pop_front());
      n_pops++;
    end
    if (redirect_valid) begin
      mq.delete();
      if (imem_read && !imem_resp) begin
        m_discard = 1'b1;
        m_pend    = redirect_pc;
      end else begin
        m_discard = 1'b0;
        m_next    = redirect_pc;
      end
    end else if (imem_read && imem_resp) begin
      if (m_discard) begin
        m_discard = 1'b0;
        m_next    = m_pend;
      end else begin
        if (!byp) begin
          e.instr = imem_rdata;
          e.pc    = open_addr;
          mq.push_back(e);
        end
        m_next = open_addr + AW'(2);
      end
    end
    rd_prev   = imem_read;
    resp_prev = imem_resp;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_resp      = 1'b0;
    req_new        = 1'b0;
    if (imem_read) begin
      if (resp_prev || !rd_prev) begin
        req_new = 1'b1;
        age     = 0;
        cur_lat = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      end else begin
        age++;
      end
      if (age >= cur_lat) begin
        imem_resp  = 1'b1;
        imem_rdata = IW'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_resp = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; deq_ready = 1'b1; lat_mode = 1;
    #2 reset = 1'b1;
    #10;
    n_checks++; if (imem_read !== 1'b0) begin n_errors++; $display("FAIL rst_read: got %b expected 0", imem_read); end
    n_checks++; if (deq_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b expected 0", deq_valid); end
    n_checks++; if (count !== '0) begin n_errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_checks++; if (deq_instr !== '0) begin n_errors++; $display("FAIL rst_instr: got %h expected 0", deq_instr); end
    n_checks++; if (deq_pc !== '0) begin n_errors++; $display("FAIL rst_pc: got %h expected 0", deq_pc); end
    n_checks++; if (imem_byte_enable !== 2'b11) begin n_errors++; $display("FAIL byte_en: got %b expected 11", imem_byte_enable); end
    do_reset();
    tick();
    n_checks++;
    if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin
      n_errors++; $display("FAIL first_req: got read %b addr %h expected read 1 addr 0000", imem_read, imem_address);
    end
  endtask

  task automatic test_sequential();
    repeat (12) tick();
    n_checks++;
    if (req_log.size() < 3) begin
      n_errors++; $display("FAIL seq_reqs: got %0d requests expected at least 3", req_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (req_log[i] !== AW'(2 * i)) begin
          n_errors++; $display("FAIL seq_addr%0d: got %h expected %h", i, req_log[i], AW'(2 * i));
        end
      end
    end
    n_checks++;
    if (max_count > 1) begin n_errors++; $display("FAIL seq_max_count: got %0d expected <= 1", max_count); end
  endtask

  task automatic test_fill();
    deq_ready = 1'b0; lat_mode = 1;
    do_reset();
    repeat (16) tick();
    n_checks++;
    if (req_log.size() != 4) begin
      n_errors++; $display("FAIL fill_reqs: got %0d requests expected 4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (req_log[i] !== AW'(2 * i)) begin
          n_errors++; $display("FAIL fill_addr%0d: got %h expected %h", i, req_log[i], AW'(2 * i));
        end
      end
    end
    n_checks++; if (count !== CW'(4)) begin n_errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (imem_read !== 1'b0) begin n_errors++; $display("FAIL fill_idle: got read %b expected 0", imem_read); end
    deq_ready = 1'b1;
    for (int i = 0; i < 10 && req_log.size() < 5; i++) tick();
    n_checks++;
    if (req_log.size() < 5) begin
      n_errors++; $display("FAIL resume_timeout: got %0d requests expected 5", req_log.size());
    end else if (req_log[4] !== 16'h0008) begin
      n_errors++; $display("FAIL resume_addr: got %h expected 0008", req_log[4]);
    end
  endtask

  task automatic test_redirect_drain();
    bit found = 1'b0;
    bit resp_seen = 1'b0;
    deq_ready = 1'b1; lat_mode = 1;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (req_new && imem_address == 16'h0004) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL drain_setup: got no request to 0004 expected one");
    end else begin
      cur_lat = 3;
      tick();
      redirect_pc = 16'h3000; redirect_valid = 1'b1;
      tick();
      for (int i = 0; i < 12 && !req_new; i++) begin
        n_checks++;
        if (count !== '0) begin n_errors++; $display("FAIL drain_count: got %0d expected 0", count); end
        if (!resp_seen) begin
          n_checks++;
          if (imem_read !== 1'b1 || imem_address !== 16'h0004) begin
            n_errors++; $display("FAIL drain_hold: got read %b addr %h expected read 1 addr 0004", imem_read, imem_address);
          end
        end
        if (imem_resp) resp_seen = 1'b1;
        tick();
      end
      n_checks++;
      if (!req_new || imem_address !== 16'h3000) begin
        n_errors++; $display("FAIL drain_next: got new %b addr %h expected new 1 addr 3000", req_new, imem_address);
      end
    end
  endtask

  task automatic test_redirect_resp();
    bit found = 1'b0;
    deq_ready = 1'b0; lat_mode = 2;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_resp) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL rr_setup: got no response expected one");
    end else begin
      redirect_pc = 16'h4000; redirect_valid = 1'b1;
      tick();
      n_checks++;
      if (count !== '0 || deq_valid !== 1'b0) begin
        n_errors++; $display("FAIL rr_flush: got count %0d valid %b expected count 0 valid 0", count, deq_valid);
      end
      for (int i = 0; i < 10 && !req_new; i++) tick();
      n_checks++;
      if (!req_new || imem_address !== 16'h4000) begin
        n_errors++; $display("FAIL rr_next: got new %b addr %h expected new 1 addr 4000", req_new, imem_address);
      end
    end
  endtask

  task automatic test_wrap();
    int k = -1;
    deq_ready = 1'b1; lat_mode = 1;
    req_log.delete();
    redirect_pc = 16'hFFFE; redirect_valid = 1'b1;
    tick();
    for (int i = 0; i < 24 && req_log.size() < 4; i++) tick();
    for (int i = 0; i + 1 < req_log.size(); i++) if (k < 0 && req_log[i] == 16'hFFFE) k = i;
    n_checks++;
    if (k < 0) begin
      n_errors++; $display("FAIL wrap_setup: got no request pair at FFFE expected one");
    end else if (req_log[k+1] !== 16'h0000) begin
      n_errors++; $display("FAIL wrap_addr: got %h expected 0000", req_log[k+1]);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    deq_ready = 1'b0; lat_mode = 1;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (count == CW'(2) && imem_read) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL mid_setup: got count %0d read %b expected count 2 read 1", count, imem_read);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++; if (imem_read !== 1'b0) begin n_errors++; $display("FAIL mid_read: got %b expected 0", imem_read); end
    n_checks++; if (count !== '0) begin n_errors++; $display("FAIL mid_count: got %0d expected 0", count); end
    n_checks++; if (deq_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b expected 0", deq_valid); end
    n_checks++;
    if (deq_pc !== '0 || deq_instr !== '0) begin
      n_errors++; $display("FAIL mid_deq: got pc %h instr %h expected 0", deq_pc, deq_instr);
    end
    imem_resp = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    tick();
    tick();
    n_checks++;
    if (req_log.size() < 1 || req_log[0] !== 16'h0000) begin
      n_errors++; $display("FAIL mid_restart: got %0d requests first %h expected first 0000",
                           req_log.size(), (req_log.size() > 0) ? req_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    deq_ready = 1'b1; lat_mode = 0; n_pops = 0;
    for (int i = 0; i < 800; i++) begin
      deq_ready = (i % 128 < 64) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = AW'($urandom) & 16'hFFFE;
      end
      tick();
    end
    n_checks++;
    if (n_pops < 50) begin n_errors++; $display("FAIL rand_progress: got %0d dequeues expected at least 50", n_pops); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_redirect_drain();
    test_redirect_resp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined LC-3b core.
- Generates sequential fetch PCs and drives the instruction-memory read handshake (one outstanding request).
- Buffers returned instructions, each with its PC, in a DEPTH-entry FIFO feeding the IF/ID pipeline register.
- Supports branch/exception redirect with flush, including discard of an in-flight response.

Parameters:
ADDR_WIDTH, 16, fetch address / PC width
INSTR_WIDTH, 16, instruction word width
DEPTH, 4, queue entries (>=2, power of two)
RESET_PC, 0, PC fetched first after reset
PC_STEP, 2, byte increment between sequential fetches

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_address  out  ADDR_WIDTH  fetch address, equals req_pc
imem_read  out  1  read request, held until imem_resp
imem_rdata  in  INSTR_WIDTH  instruction data, valid with imem_resp
imem_resp  in  1  one-cycle response pulse
imem_byte_enable  out  2  constant 2'b11
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch PC
deq_ready  in  1  decode accepts the head entry
deq_valid  out  1  head entry valid
deq_instr  out  INSTR_WIDTH  head instruction
deq_pc  out  ADDR_WIDTH  PC of head instruction
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset, asynchronous: fetch_pc=RESET_PC, queue empty, count=0, state IDLE, imem_read=0, deq_valid=0, deq_instr=0, deq_pc=0.
- State outputs: imem_read=1 in REQ and DRAIN, else 0. imem_address=req_pc, stable while imem_read=1.
- space = (count < DEPTH), using the registered count; a same-cycle dequeue does not create space.
- IDLE:
  - redirect_valid: fetch_pc<=redirect_pc, flush, stay IDLE.
  - else if space: req_pc<=fetch_pc, go to REQ.
- REQ:
  - imem_resp without redirect: enqueue {imem_rdata, req_pc}; fetch_pc<=req_pc+PC_STEP (wraps mod 2^ADDR_WIDTH).
  - Then, if count+1 < DEPTH (after any same-cycle dequeue), req_pc<=req_pc+PC_STEP and stay in REQ (back-to-back fetch). Otherwise go to IDLE.
  - redirect_valid without imem_resp: flush; pend_pc<=redirect_pc; go to DRAIN. The in-flight request is never aborted.
  - redirect_valid with imem_resp: response discarded; flush; fetch_pc<=redirect_pc; go to IDLE.
- DRAIN:
  - imem_read stays high at the old address.
  - A further redirect overwrites pend_pc.
  - On imem_resp: data discarded; fetch_pc<=pend_pc (or redirect_pc if redirect_valid is high the same cycle); go to IDLE.
- Dequeue:
  - deq_valid = (count != 0).
  - Head is popped when deq_valid && deq_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Flush: count<=0 and pointers reset at the edge. A dequeue handshake in the redirect cycle still counts as taken by decode.
- Overflow is impossible: requests are issued only with a free slot reserved. An assertion flags enqueue while count==DEPTH.
- Latency: response to deq_valid is 1 cycle. Reset release to first imem_read is 1 cycle (IDLE->REQ).
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0, imem_resp is accepted (no redirect) and deq_ready=1, the response drives deq_valid/deq_instr/deq_pc combinationally that cycle and is not written to the queue. Response-to-decode latency is 0.
- Undefined: deq outputs are driven only from queue storage; latency is 1 cycle.

Test Plan:
1. Reset release, memory responds 1 cycle after each read, deq_ready=1 -> imem_address sequence 0x0000, 0x0002, 0x0004; deq_pc follows 1 cycle after each resp; count never exceeds 1.
2. deq_ready=0, DEPTH=4 -> exactly 4 fetches (0x0000-0x0006); imem_read then drops; count=4; raising deq_ready resumes fetching at 0x0008.
3. Redirect to 0x3000 while a request to 0x0004 is pending with 3-cycle latency -> imem_read held at 0x0004 until resp; that data is discarded; next request is 0x3000; queue empty in the meantime.
4. Redirect to 0x4000 in the same cycle as imem_resp -> response not enqueued; count=0; next imem_address=0x4000.
5. Sequential fetch from 0xFFFE -> next fetch address wraps to 0x0000.
6. Reset asserted mid-REQ with queue holding 2 entries -> outputs clear immediately (asynchronous); after release, fetch restarts at RESET_PC.
